cam_lookup_engine: RTL and testbench

CAM_LOOKUP_ENGINE -- requirements
Module: cam_lookup_engine

---
 rtl/cam_lookup_engine_if.sv | 44 ++++
 rtl/cam_lookup_engine.sv | 170 +++++++++++++++++
 tb/tb_cam_lookup_engine.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_lookup_engine_if.sv
// cam_lookup_engine_if: groups the request/response handshake and the CAM
// search/write ports of cam_lookup_engine into one bundle.
//   req_*        requester -> engine (valid/ready, op 0=lookup 1=insert, key)
//   rsp_*        engine -> consumer (valid/ready, hit, index, evict)
//   cam_write_*  engine -> CAM write port
//   cam_search_* engine -> CAM search request, CAM -> engine search result
// Modports: slave = engine side, master = requester/CAM side.
interface cam_lookup_engine_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_op_i;
  logic [WIDTH-1:0]      req_key_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic                  rsp_hit_o;
  logic [ADDR_WIDTH-1:0] rsp_index_o;
  logic                  rsp_evict_o;
  logic                  cam_write_enable_o;
  logic [ADDR_WIDTH-1:0] cam_write_index_o;
  logic [WIDTH-1:0]      cam_write_data_o;
  logic                  cam_search_enable_o;
  logic [WIDTH-1:0]      cam_search_data_o;
  logic                  cam_search_valid_i;
  logic [ADDR_WIDTH-1:0] cam_search_index_i;

  modport slave (
    input  req_valid_i, req_op_i, req_key_i, rsp_ready_i,
           cam_search_valid_i, cam_search_index_i,
    output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_evict_o,
           cam_write_enable_o, cam_write_index_o, cam_write_data_o,
           cam_search_enable_o, cam_search_data_o
  );

  modport master (
    output req_valid_i, req_op_i, req_key_i, rsp_ready_i,
           cam_search_valid_i, cam_search_index_i,
    input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_evict_o,
           cam_write_enable_o, cam_write_index_o, cam_write_data_o,
           cam_search_enable_o, cam_search_data_o
  );
endinterface

// File: rtl/cam_lookup_engine.sv
// cam_lookup_engine: accepts one lookup/insert request at a time, searches an
// external CAM, masks stale CAM rows with an engine-owned valid vector and, on
// an insert miss, allocates the lowest free row or evicts round-robin.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous reset, active low
//   bus    - cam_lookup_engine_if.slave (request, response, CAM search/write)
//   hit_count_o / miss_count_o - 16-bit saturating response counters, present
//   only when the macro CAM_LOOKUP_STATS_EN is defined.
//
// state   | meaning
// IDLE    | ready for a request
// SEARCH  | search enable driven with captured key
// WAIT    | CAM result sampled, hit/allocate decision
// WRITE   | CAM write of key into target row
// RESP    | response held until consumer takes it
module cam_lookup_engine #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  cam_lookup_engine_if.slave bus
`ifdef CAM_LOOKUP_STATS_EN
  ,
  output logic [15:0] hit_count_o,
  output logic [15:0] miss_count_o
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_WAIT,
    ST_WRITE,
    ST_RESP
  } state_t;

  state_t                state;
  logic                  op_q;
  logic [WIDTH-1:0]      key_q;
  logic [DEPTH-1:0]      valid_q;
  logic [ADDR_WIDTH-1:0] ptr_q;

  logic                  hit;
  logic                  free_found;
  logic [ADDR_WIDTH-1:0] free_idx;
  logic [ADDR_WIDTH-1:0] alloc_idx;

  // A CAM match only counts if the engine itself wrote that row since reset.
  assign hit = bus.cam_search_valid_i & valid_q[bus.cam_search_index_i];

  // Lowest free row: scan from the top so the last assignment wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = ADDR_WIDTH'(i);
      end
    end
  end

  assign alloc_idx = free_found ? free_idx : ptr_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state                   <= ST_IDLE;
      op_q                    <= 1'b0;
      key_q                   <= '0;
      valid_q                 <= '0;
      ptr_q                   <= '0;
      bus.req_ready_o         <= 1'b1;
      bus.rsp_valid_o         <= 1'b0;
      bus.rsp_hit_o           <= 1'b0;
      bus.rsp_index_o         <= '0;
      bus.rsp_evict_o         <= 1'b0;
      bus.cam_write_enable_o  <= 1'b0;
      bus.cam_write_index_o   <= '0;
      bus.cam_write_data_o    <= '0;
      bus.cam_search_enable_o <= 1'b0;
      bus.cam_search_data_o   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid_i) begin
            op_q                    <= bus.req_op_i;
            key_q                   <= bus.req_key_i;
            bus.req_ready_o         <= 1'b0;
            bus.cam_search_enable_o <= 1'b1;
            bus.cam_search_data_o   <= bus.req_key_i;
            state                   <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          bus.cam_search_enable_o <= 1'b0;
          bus.cam_search_data_o   <= '0;
          state                   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (hit) begin
            bus.rsp_hit_o   <= 1'b1;
            bus.rsp_index_o <= bus.cam_search_index_i;
            bus.rsp_evict_o <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            state           <= ST_RESP;
          end else if (!op_q) begin
            bus.rsp_hit_o   <= 1'b0;
            bus.rsp_index_o <= '0;
            bus.rsp_evict_o <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            state           <= ST_RESP;
          end else begin
            // Response fields are loaded now; rsp_valid_o follows after WRITE.
            bus.rsp_hit_o          <= 1'b0;
            bus.rsp_index_o        <= alloc_idx;
            bus.rsp_evict_o        <= ~free_found;
            bus.cam_write_enable_o <= 1'b1;
            bus.cam_write_index_o  <= alloc_idx;
            bus.cam_write_data_o   <= key_q;
            state                  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          valid_q[bus.cam_write_index_o] <= 1'b1;
          if (bus.rsp_evict_o) begin
            ptr_q <= ptr_q + 1'b1;
          end
          bus.cam_write_enable_o <= 1'b0;
          bus.cam_write_index_o  <= '0;
          bus.cam_write_data_o   <= '0;
          bus.rsp_valid_o        <= 1'b1;
          state                  <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            bus.req_ready_o <= 1'b1;
            state           <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CAM_LOOKUP_STATS_EN
  logic rsp_fire;
  assign rsp_fire = (state == ST_RESP) && bus.rsp_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else if (rsp_fire) begin
      if (bus.rsp_hit_o) begin
        if (hit_count_o != 16'hFFFF) hit_count_o <= hit_count_o + 16'd1;
      end else begin
        if (miss_count_o != 16'hFFFF) miss_count_o <= miss_count_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cam_lookup_engine.sv
module tb_cam_lookup_engine;
  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cam_lookup_engine_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

`ifdef CAM_LOOKUP_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  cam_lookup_engine #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
`ifdef CAM_LOOKUP_STATS_EN
    ,
    .hit_count_o (hit_count),
    .miss_count_o(miss_count)
`endif
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  bit hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // External CAM model: row 0 starts holding key 0 as a stale entry.
  logic [WIDTH-1:0] row_key [DEPTH] = '{default: '0};
  bit row_present [DEPTH] = '{0: 1'b1, default: 1'b0};

  function automatic logic [AW:0] cam_match(input logic [WIDTH-1:0] key);
    for (int i = 0; i < DEPTH; i++)
      if (row_present[i] && row_key[i] == key) return {1'b1, AW'(i)};
    return '0;
  endfunction

  always @(posedge clk) begin
    if (bus.cam_write_enable_o) begin
      row_key[bus.cam_write_index_o]     <= bus.cam_write_data_o;
      row_present[bus.cam_write_index_o] <= 1'b1;
    end
    if (bus.cam_search_enable_o)
      {bus.cam_search_valid_i, bus.cam_search_index_i} <= cam_match(bus.cam_search_data_o);
    else
      {bus.cam_search_valid_i, bus.cam_search_index_i} <= {1'b0, AW'($urandom)};
  end

  // Reference model: engine occupancy and round-robin pointer.
  typedef struct {
    logic [WIDTH-1:0] key;
    bit hit;
    int idx;
    bit evict;
    int lat;
    int acc;
  } exp_t;
  typedef struct {
    int idx;
    logic [WIDTH-1:0] data;
  } wr_t;

  exp_t rq[$];
  wr_t  wq[$];
  bit   mvalid [DEPTH];
  int   mptr = 0;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;
    mptr = 0;
  endtask

  task automatic model_req(input bit op, input logic [WIDTH-1:0] key);
    exp_t e;
    int m = -1;
    int f = -1;
    e.key = key; e.acc = cyc; e.hit = 0; e.idx = 0; e.evict = 0; e.lat = 3;
    for (int i = DEPTH - 1; i >= 0; i--) if (row_present[i] && row_key[i] == key) m = i;
    if (m >= 0 && mvalid[m]) begin
      e.hit = 1; e.idx = m;
    end else if (op) begin
      for (int i = DEPTH - 1; i >= 0; i--) if (!mvalid[i]) f = i;
      if (f >= 0) e.idx = f;
      else begin
        e.idx = mptr; e.evict = 1; mptr = (mptr + 1) % DEPTH;
      end
      mvalid[e.idx] = 1'b1;
      e.lat = 4;
      wq.push_back('{e.idx, key});
    end
    rq.push_back(e);
  endtask

  task automatic issue_req(input bit op, input logic [WIDTH-1:0] key);
    int n = 0;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b1; bus.req_op_i = op; bus.req_key_i = key;
    do begin @(negedge clk); n++; end while (!bus.req_ready_o && n < 200);
    if (!bus.req_ready_o) chk("accept_timeout", bus.req_ready_o, 1);
    else model_req(op, key);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (rq.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (rq.size() != 0) begin
      chk("rsp_timeout", rq.size(), 0);
      rq.delete(); wq.delete();
    end
  endtask

  task automatic do_req(input bit op, input logic [WIDTH-1:0] key);
    issue_req(op, key);
    wait_done();
  endtask

  // Consumer: random backpressure unless holding.
  initial begin
    bus.rsp_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.rsp_ready_i = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit seen = 0;
    int mh = 0;
    int mm = 0;
    wr_t w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0; mh = 0; mm = 0;
      end else begin
`ifdef CAM_LOOKUP_STATS_EN
        chk("hit_count", hit_count, mh);
        chk("miss_count", miss_count, mm);
`endif
        chk("search_write_overlap", bus.cam_search_enable_o & bus.cam_write_enable_o, 0);
        if (bus.cam_search_enable_o) begin
          if (rq.size() == 0) chk("unexpected_search", bus.cam_search_enable_o, 0);
          else chk("search_key", bus.cam_search_data_o, rq[0].key);
        end
        if (bus.cam_write_enable_o) begin
          if (wq.size() == 0) chk("unexpected_write", bus.cam_write_enable_o, 0);
          else begin
            w = wq.pop_front();
            chk("write_index", bus.cam_write_index_o, w.idx);
            chk("write_data", bus.cam_write_data_o, w.data);
          end
        end
        if (bus.rsp_valid_o) begin
          if (rq.size() == 0) chk("unexpected_rsp", bus.rsp_valid_o, 0);
          else begin
            if (!seen) begin
              chk("latency", cyc - rq[0].acc, rq[0].lat);
              seen = 1;
            end
            chk("rsp_hit", bus.rsp_hit_o, rq[0].hit);
            chk("rsp_index", bus.rsp_index_o, rq[0].idx);
            chk("rsp_evict", bus.rsp_evict_o, rq[0].evict);
            chk("req_ready_in_resp", bus.req_ready_o, 0);
            if (bus.rsp_ready_i) begin
              if (rq[0].hit) mh = (mh == 65535) ? mh : mh + 1;
              else mm = (mm == 65535) ? mm : mm + 1;
              void'(rq.pop_front());
              seen = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] k;
    int n;
    bus.req_valid_i = 1'b0; bus.req_op_i = 1'b0; bus.req_key_i = '0;
    model_reset();
    #1;
    chk("reset_rsp_valid", bus.rsp_valid_o, 0);
    chk("reset_rsp_hit", bus.rsp_hit_o, 0);
    chk("reset_rsp_index", bus.rsp_index_o, 0);
    chk("reset_rsp_evict", bus.rsp_evict_o, 0);
    chk("reset_search_en", bus.cam_search_enable_o, 0);
    chk("reset_write_en", bus.cam_write_enable_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", bus.req_ready_o, 1);

    // Stale CAM row 0 holds key 0: lookup must miss.
    do_req(1'b0, 32'h0);
    // Insert into empty engine.
    do_req(1'b1, 32'hDEAD_BEEF);
    // Fill the rest, then evict round-robin through a full wrap and one more.
    for (int i = 1; i < 65; i++) do_req(1'b1, ($urandom & 32'hFFFF_FF00) | 32'(i));
    // Resident key at row 7 inserted again: hit, no write.
    k = row_key[7];
    do_req(1'b1, k);
    do_req(1'b0, k);

    // Random mix of lookups and inserts.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) != 0) k = row_key[$urandom_range(0, DEPTH - 1)];
      else k = $urandom;
      do_req(1'($urandom_range(0, 1)), k);
    end

    // Hold the response for 5 cycles.
    hold = 1'b1;
    issue_req(1'b0, row_key[3]);
    n = 0;
    while (!bus.rsp_valid_o && n < 50) begin @(negedge clk); n++; end
    chk("hold_rsp_seen", bus.rsp_valid_o, 1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_req_ready", bus.req_ready_o, 0);
      chk("hold_rsp_valid", bus.rsp_valid_o, 1);
    end
    hold = 1'b0;
    wait_done();

    // Reset during WRITE of an evicting insert.
    issue_req(1'b1, 32'hC0DE_0000 | 32'($urandom_range(0, 255)) << 8);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.cam_write_enable_o && n < 20);
    chk("write_seen_before_reset", bus.cam_write_enable_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_drops_write_en", bus.cam_write_enable_o, 0);
    chk("reset_drops_rsp_valid", bus.rsp_valid_o, 0);
    rq.delete(); wq.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("no_rsp_after_reset", bus.rsp_valid_o, 0);
    end
    // Valid vector cleared: resident CAM key misses, then reinsert and find it.
    k = row_key[3];
    do_req(1'b0, k);
    do_req(1'b1, k);
    do_req(1'b0, k);
    for (int i = 0; i < 20; i++) do_req(1'($urandom_range(0, 1)), $urandom);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
